// File: rtl/eth_tx_pkg.sv
// Shared types and default constants for the Ethernet transmit packet scheduler.
// The optional serializer watchdog is enabled by defining TX_WATCHDOG_EN.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } tx_state_e;

    typedef enum logic {
        PKT_VIDEO = 1'b0,
        PKT_AUDIO = 1'b1
    } pkt_kind_e;

    localparam int DEF_PIXELS_PER_PKT      = 320;
    localparam int DEF_FRAME_PIXELS        = 76800;
    localparam int DEF_AUDIO_BYTES_PER_PKT = 64;
    localparam int DEF_AUDIO_THRESH        = 64;
    localparam int DEF_IFG_CYCLES          = 48;
    localparam int DEF_WDOG_CYCLES         = 4096;

    localparam int ADDR_W  = 17;
    localparam int LEN_W   = 10;
    localparam int LINE_W  = 8;
    localparam int LEVEL_W = 10;

endpackage

// File: rtl/tx_down_counter.sv
// Loadable down-counter with a zero flag; shared by the inter-frame gap and
// the watchdog, which are never active at the same time.
module tx_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/eth_tx_scheduler.sv
// Chooses video or audio packets for the dibit serializer, tracks the video
// read pointer through the frame and enforces the inter-frame gap.
// Define TX_WATCHDOG_EN to abort a serializer that never reports tx_done.
module eth_tx_scheduler
    import eth_tx_pkg::*;
#(
    parameter int PIXELS_PER_PKT      = DEF_PIXELS_PER_PKT,
    parameter int FRAME_PIXELS        = DEF_FRAME_PIXELS,
    parameter int AUDIO_BYTES_PER_PKT = DEF_AUDIO_BYTES_PER_PKT,
    parameter int AUDIO_THRESH        = DEF_AUDIO_THRESH,
    parameter int IFG_CYCLES          = DEF_IFG_CYCLES,
    parameter int WDOG_CYCLES         = DEF_WDOG_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [LEVEL_W-1:0] audio_level,
    output logic               tx_start,
    input  logic               tx_ack,
    output logic               tx_kind,
    output logic [ADDR_W-1:0]  tx_addr,
    output logic [LEN_W-1:0]   tx_len,
    input  logic               tx_done,
    output logic               tx_abort,
    output logic               frame_start,
    output logic [LINE_W-1:0]  line_idx,
    output logic               wdog_err,
    output logic               busy,
    output tx_state_e          dbg_state
);

    // Counter is sized for whichever phase needs the longer count.
    localparam int CNT_W = $clog2(((WDOG_CYCLES > IFG_CYCLES) ? WDOG_CYCLES : IFG_CYCLES) + 1);

    localparam logic [ADDR_W-1:0]  PIX_L      = ADDR_W'(PIXELS_PER_PKT);
    localparam logic [ADDR_W-1:0]  FRAME_L    = ADDR_W'(FRAME_PIXELS);
    localparam logic [LEN_W-1:0]   VID_LEN_L  = LEN_W'(PIXELS_PER_PKT);
    localparam logic [LEN_W-1:0]   AUD_LEN_L  = LEN_W'(AUDIO_BYTES_PER_PKT);
    localparam logic [LEVEL_W-1:0] THRESH_L   = LEVEL_W'(AUDIO_THRESH);
    localparam logic [CNT_W-1:0]   IFG_LOAD_L = CNT_W'(IFG_CYCLES - 1);

    // Handshake: a command is offered while tx_start is high and all command
    // fields stay constant; it is consumed in the first cycle that tx_ack is
    // high, after which tx_start drops and is not re-raised for that packet.

    tx_state_e          state_q, state_d;
    logic               tx_start_q, tx_start_d;
    pkt_kind_e          kind_q, kind_d;
    logic [ADDR_W-1:0]  tx_addr_q, tx_addr_d;
    logic [LEN_W-1:0]   tx_len_q, tx_len_d;
    logic               frame_start_q, frame_start_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic               last_audio_q, last_audio_d;
    logic               busy_q, busy_d;

    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_dec;
    logic               cnt_zero;
    logic [ADDR_W-1:0]  ptr_next;

`ifdef TX_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LOAD_L = CNT_W'(WDOG_CYCLES - 2);
    logic tx_abort_q, tx_abort_d;
    logic wdog_err_q, wdog_err_d;
`endif

    assign ptr_next = ptr_q + PIX_L;

    always_comb begin
        state_d       = state_q;
        tx_start_d    = tx_start_q;
        kind_d        = kind_q;
        tx_addr_d     = tx_addr_q;
        tx_len_d      = tx_len_q;
        frame_start_d = 1'b0;
        ptr_d         = ptr_q;
        line_d        = line_q;
        last_audio_d  = last_audio_q;
        cnt_load      = 1'b0;
        cnt_load_val  = '0;
        cnt_dec       = 1'b0;
`ifdef TX_WATCHDOG_EN
        tx_abort_d    = 1'b0;
        wdog_err_d    = wdog_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ARB;
                end
            end

            ST_ARB: begin
                // Video is always pending; audio only alternates with it.
                if ((audio_level >= THRESH_L) && !last_audio_q) begin
                    kind_d       = PKT_AUDIO;
                    tx_addr_d    = '0;
                    tx_len_d     = AUD_LEN_L;
                    last_audio_d = 1'b1;
                end else begin
                    kind_d       = PKT_VIDEO;
                    tx_addr_d    = ptr_q;
                    tx_len_d     = VID_LEN_L;
                    last_audio_d = 1'b0;
                end
                tx_start_d = 1'b1;
                state_d    = ST_ISSUE;
            end

            ST_ISSUE: begin
                if (tx_ack) begin
                    tx_start_d = 1'b0;
                    state_d    = ST_WAIT_DONE;
                    if (kind_q == PKT_VIDEO) begin
                        frame_start_d = (tx_addr_q == '0);
                        if (ptr_next == FRAME_L) begin
                            ptr_d  = '0;
                            line_d = '0;
                        end else begin
                            ptr_d  = ptr_next;
                            line_d = line_q + 1'b1;
                        end
                    end
`ifdef TX_WATCHDOG_EN
                    cnt_load     = 1'b1;
                    cnt_load_val = WDOG_LOAD_L;
`endif
                end
            end

            ST_WAIT_DONE: begin
`ifdef TX_WATCHDOG_EN
                // The abort pulse itself plays the role of tx_done one cycle later.
                if (tx_done || tx_abort_q) begin
                    state_d      = ST_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = IFG_LOAD_L;
                end else if (cnt_zero) begin
                    tx_abort_d = 1'b1;
                    wdog_err_d = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
`else
                if (tx_done) begin
                    state_d      = ST_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = IFG_LOAD_L;
                end
`endif
            end

            ST_GAP: begin
                if (cnt_zero) begin
                    state_d = enable ? ST_ARB : ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                tx_start_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tx_start_q    <= 1'b0;
            kind_q        <= PKT_VIDEO;
            tx_addr_q     <= '0;
            tx_len_q      <= '0;
            frame_start_q <= 1'b0;
            ptr_q         <= '0;
            line_q        <= '0;
            last_audio_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_start_q    <= tx_start_d;
            kind_q        <= kind_d;
            tx_addr_q     <= tx_addr_d;
            tx_len_q      <= tx_len_d;
            frame_start_q <= frame_start_d;
            ptr_q         <= ptr_d;
            line_q        <= line_d;
            last_audio_q  <= last_audio_d;
            busy_q        <= busy_d;
        end
    end

`ifdef TX_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_abort_q <= 1'b0;
            wdog_err_q <= 1'b0;
        end else begin
            tx_abort_q <= tx_abort_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign tx_abort = tx_abort_q;
    assign wdog_err = wdog_err_q;
`else
    assign tx_abort = 1'b0;
    assign wdog_err = 1'b0;
`endif

    tx_down_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign tx_start    = tx_start_q;
    assign tx_kind     = kind_q;
    assign tx_addr     = tx_addr_q;
    assign tx_len      = tx_len_q;
    assign frame_start = frame_start_q;
    assign line_idx    = line_q;
    assign busy        = busy_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed bench for eth_tx_scheduler: a table of per-packet vectors plus
// hand-written sequences for frame wrap, enable drop, reset and watchdog.
module tb_eth_tx_scheduler;
    import eth_tx_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [9:0]  audio_level;
    logic        tx_start;
    logic        tx_ack;
    logic        tx_kind;
    logic [16:0] tx_addr;
    logic [9:0]  tx_len;
    logic        tx_done;
    logic        tx_abort;
    logic        frame_start;
    logic [7:0]  line_idx;
    logic        wdog_err;
    logic        busy;
    tx_state_e   dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int level;
        int ack_dly;
        int done_dly;
        int kind;
        int addr;
        int len;
        int line;
        int fs;
    } vec_t;

    vec_t vecs[13];

    eth_tx_scheduler #(
        .WDOG_CYCLES(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .audio_level (audio_level),
        .tx_start    (tx_start),
        .tx_ack      (tx_ack),
        .tx_kind     (tx_kind),
        .tx_addr     (tx_addr),
        .tx_len      (tx_len),
        .tx_done     (tx_done),
        .tx_abort    (tx_abort),
        .frame_start (frame_start),
        .line_idx    (line_idx),
        .wdog_err    (wdog_err),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=%0d cycles required=finish", cyc);
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_start(input string tag);
        int waited;
        waited = 0;
        while (tx_start !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        check({tag, "_start_seen"}, tx_start, 1);
    endtask

    // One full packet: wait for the command, hold off ack, accept, then tx_done.
    task automatic do_pkt(input vec_t v, input string tag, output int start_cyc);
        logic        stable;
        logic        k0;
        logic [16:0] a0;
        logic [9:0]  l0;
        audio_level = v.level[9:0];
        wait_start(tag);
        start_cyc = cyc;
        check({tag, "_kind"}, tx_kind, v.kind);
        check({tag, "_addr"}, tx_addr, v.addr);
        check({tag, "_len"}, tx_len, v.len);
        check({tag, "_line"}, line_idx, v.line);
        k0 = tx_kind;
        a0 = tx_addr;
        l0 = tx_len;
        stable = 1'b1;
        for (int k = 0; k < v.ack_dly; k++) begin
            tx_ack = 1'b0;
            tick();
            if (tx_start !== 1'b1 || tx_kind !== k0 || tx_addr !== a0 || tx_len !== l0)
                stable = 1'b0;
        end
        if (v.ack_dly > 0) check({tag, "_hold_stable"}, stable, 1);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        check({tag, "_start_drop"}, tx_start, 0);
        check({tag, "_frame_start"}, frame_start, v.fs);
        repeat (v.done_dly - 1) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        int s;
        int prev_s;
        int en_cyc;
        int m_cyc;
        int a_cyc;
        int n;
        logic seen;
        vec_t v;

        //            level ack done kind addr  len line fs
        vecs[0]  = '{0,    0,  20,  0,   0,    320, 0,  1};
        vecs[1]  = '{0,    0,  20,  0,   320,  320, 1,  0};
        vecs[2]  = '{0,    0,  20,  0,   640,  320, 2,  0};
        vecs[3]  = '{100,  0,  20,  1,   0,    64,  3,  0};
        vecs[4]  = '{100,  0,  20,  0,   960,  320, 3,  0};
        vecs[5]  = '{100,  0,  20,  1,   0,    64,  4,  0};
        vecs[6]  = '{100,  0,  20,  0,   1280, 320, 4,  0};
        vecs[7]  = '{63,   0,  20,  0,   1600, 320, 5,  0};
        vecs[8]  = '{63,   0,  20,  0,   1920, 320, 6,  0};
        vecs[9]  = '{64,   0,  20,  1,   0,    64,  7,  0};
        vecs[10] = '{1023, 10, 20,  0,   2240, 320, 7,  0};
        vecs[11] = '{1023, 3,  20,  1,   0,    64,  8,  0};
        vecs[12] = '{0,    0,  20,  0,   2560, 320, 8,  0};

        rst = 1'b1;
        enable = 1'b0;
        tx_ack = 1'b0;
        tx_done = 1'b0;
        audio_level = '0;
        repeat (3) tick();
        check("rst_tx_start", tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_addr", tx_addr, 0);
        check("rst_tx_len", tx_len, 0);
        check("rst_line_idx", line_idx, 0);
        check("rst_tx_abort", tx_abort, 0);
        rst = 1'b0;
        tick();
        tick();
        check("idle_busy", busy, 0);

        en_cyc = cyc;
        enable = 1'b1;
        prev_s = 0;
        for (int i = 0; i < 13; i++) begin
            do_pkt(vecs[i], $sformatf("vec%0d", i), s);
            if (i == 0) check("enable_to_start", s - en_cyc, 2);
            else check($sformatf("vec%0d_spacing", i), s - prev_s,
                       vecs[i-1].ack_dly + vecs[i-1].done_dly + IFG_SPACING());
            prev_s = s;
        end

        // Frame wrap: run video through line 239 and back to line 0.
        for (int i = 9; i <= 240; i++) begin
            n = i % 240;
            v = '{0, 0, 1, 0, n * 320, 320, n, (n == 0) ? 1 : 0};
            do_pkt(v, $sformatf("wrap%0d", i), s);
        end

        // Enable drops while the packet is in flight.
        audio_level = '0;
        wait_start("edrop");
        check("edrop_addr", tx_addr, 320);
        check("edrop_line", line_idx, 1);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        enable = 1'b0;
        repeat (4) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (47) tick();
        check("edrop_busy_last_gap", busy, 1);
        tick();
        check("edrop_busy_idle", busy, 0);
        check("edrop_state_idle", dbg_state, ST_IDLE);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (tx_start !== 1'b0) seen = 1'b1;
        end
        check("edrop_no_start", seen, 0);
        check("edrop_line_kept", line_idx, 2);

        enable = 1'b1;
        tick();
        tick();
        check("reen_start", tx_start, 1);
        check("reen_addr", tx_addr, 640);

        // Reset while a command is being offered.
        rst = 1'b1;
        tick();
        check("rstiss_tx_start", tx_start, 0);
        check("rstiss_tx_kind", tx_kind, 0);
        check("rstiss_tx_addr", tx_addr, 0);
        check("rstiss_tx_len", tx_len, 0);
        check("rstiss_frame_start", frame_start, 0);
        check("rstiss_line_idx", line_idx, 0);
        check("rstiss_busy", busy, 0);
        check("rstiss_tx_abort", tx_abort, 0);
        check("rstiss_wdog_err", wdog_err, 0);
        rst = 1'b0;

        // First grant after reset treats the previous packet as video.
        v = '{100, 0, 5, 1, 0, 64, 0, 0};
        do_pkt(v, "post_rst_audio", s);
        v = '{100, 0, 5, 0, 0, 320, 0, 1};
        do_pkt(v, "post_rst_video", s);

`ifdef TX_WATCHDOG_EN
        audio_level = '0;
        wait_start("wdog");
        tx_ack = 1'b1;
        m_cyc = cyc;
        tick();
        tx_ack = 1'b0;
        n = 0;
        while (tx_abort !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        a_cyc = cyc;
        check("wdog_abort_seen", tx_abort, 1);
        check("wdog_abort_delay", a_cyc - m_cyc, 16);
        check("wdog_err_set", wdog_err, 1);
        tick();
        check("wdog_abort_pulse", tx_abort, 0);
        wait_start("wdog_next");
        check("wdog_next_delay", cyc - a_cyc, 50);
        check("wdog_err_sticky", wdog_err, 1);
`else
        m_cyc = 0;
        a_cyc = 0;
        check("no_wdog_abort", tx_abort, m_cyc);
        check("no_wdog_err", wdog_err, a_cyc);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Cycles from tx_done to the next tx_start beyond the done delay itself.
    function automatic int IFG_SPACING();
        return DEF_IFG_CYCLES + 2;
    endfunction

endmodule
